axi_lite_initiator: RTL and testbench

//  Single-beat AXI4 initiator that issues one read or write per command on an AXI bus (e.g. the pulpito_top axi_slave port).

---
 rtl/axi_lite_initiator.sv | 204 ++++++++++++++++++++
 tb/tb_axi_lite_initiator.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_initiator.sv
// Single-beat AXI4 initiator: one read or write per command, at most one outstanding.
// Latency: 3 cycles from command accept to rsp_valid against a zero-wait slave.
// Backpressure: cmd_ready only in IDLE; rsp held until rsp_ready; stalled AXI handshakes time out.
module axi_lite_initiator #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [2:0]              rsp_status,
  output logic                    aw_valid,
  input  logic                    aw_ready,
  output logic [ADDR_WIDTH-1:0]   aw_addr,
  output logic                    w_valid,
  input  logic                    w_ready,
  output logic [DATA_WIDTH-1:0]   w_data,
  output logic [DATA_WIDTH/8-1:0] w_strb,
  input  logic                    b_valid,
  output logic                    b_ready,
  input  logic [1:0]              b_resp,
  output logic                    ar_valid,
  input  logic                    ar_ready,
  output logic [ADDR_WIDTH-1:0]   ar_addr,
  input  logic                    r_valid,
  output logic                    r_ready,
  input  logic [DATA_WIDTH-1:0]   r_data,
  input  logic [1:0]              r_resp
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLIM = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR, WR_B, RSP} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          aw_done;
  logic          w_done;

  logic aw_hs, w_hs, timeout_hit, aw_fin, w_fin;

  assign aw_hs       = aw_valid & aw_ready;
  assign w_hs        = w_valid & w_ready;
  assign aw_fin      = aw_done | aw_hs;
  assign w_fin       = w_done | w_hs;
  assign timeout_hit = TO_EN && (timer == TLIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      timer      <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_status <= '0;
      aw_valid   <= 1'b0;
      aw_addr    <= '0;
      w_valid    <= 1'b0;
      w_data     <= '0;
      w_strb     <= '0;
      b_ready    <= 1'b0;
      ar_valid   <= 1'b0;
      ar_addr    <= '0;
      r_ready    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            timer     <= '0;
            if (cmd_write) begin
              state    <= WR;
              aw_valid <= 1'b1;
              w_valid  <= 1'b1;
              aw_addr  <= cmd_addr;
              w_data   <= cmd_wdata;
              w_strb   <= cmd_wstrb;
              aw_done  <= 1'b0;
              w_done   <= 1'b0;
            end else begin
              state    <= RD_A;
              ar_valid <= 1'b1;
              ar_addr  <= cmd_addr;
            end
          end
        end

        RD_A: begin
          if (ar_ready) begin
            ar_valid <= 1'b0;
            r_ready  <= 1'b1;
            timer    <= '0;
            state    <= RD_D;
          end else if (timeout_hit) begin
            ar_valid   <= 1'b0;
            timer      <= '0;
            rsp_valid  <= 1'b1;
            rsp_status <= 3'b111;
            rsp_rdata  <= '0;
            state      <= RSP;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        RD_D: begin
          if (r_valid) begin
            r_ready    <= 1'b0;
            timer      <= '0;
            rsp_valid  <= 1'b1;
            rsp_rdata  <= r_data;
            rsp_status <= {1'b0, r_resp};
            state      <= RSP;
          end else if (timeout_hit) begin
            r_ready    <= 1'b0;
            timer      <= '0;
            rsp_valid  <= 1'b1;
            rsp_status <= 3'b111;
            rsp_rdata  <= '0;
            state      <= RSP;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        // Address and data channels complete independently, in either order.
        WR: begin
          if (aw_hs) begin
            aw_valid <= 1'b0;
            aw_done  <= 1'b1;
          end
          if (w_hs) begin
            w_valid <= 1'b0;
            w_done  <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            b_ready <= 1'b1;
            timer   <= '0;
            state   <= WR_B;
          end else if (aw_hs || w_hs) begin
            timer <= '0;
          end else if (timeout_hit) begin
            aw_valid   <= 1'b0;
            w_valid    <= 1'b0;
            timer      <= '0;
            rsp_valid  <= 1'b1;
            rsp_status <= 3'b111;
            rsp_rdata  <= '0;
            state      <= RSP;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        WR_B: begin
          if (b_valid) begin
            b_ready    <= 1'b0;
            timer      <= '0;
            rsp_valid  <= 1'b1;
            rsp_rdata  <= '0;
            rsp_status <= {1'b0, b_resp};
            state      <= RSP;
          end else if (timeout_hit) begin
            b_ready    <= 1'b0;
            timer      <= '0;
            rsp_valid  <= 1'b1;
            rsp_status <= 3'b111;
            rsp_rdata  <= '0;
            state      <= RSP;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_initiator.sv
// Directed and randomized bench for axi_lite_initiator with a scoreboard of expected responses.
module tb_axi_lite_initiator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [2:0]  rsp_status;
  logic        aw_valid, aw_ready = 1'b0;
  logic [31:0] aw_addr;
  logic        w_valid, w_ready = 1'b0;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        b_valid = 1'b0, b_ready;
  logic [1:0]  b_resp = 2'b00;
  logic        ar_valid, ar_ready = 1'b0;
  logic [31:0] ar_addr;
  logic        r_valid = 1'b0, r_ready;
  logic [31:0] r_data = '0;
  logic [1:0]  r_resp = 2'b00;

  axi_lite_initiator #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic [2:0]  status;
  } rsp_t;

  rsp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          proto_err = 0;
  bit          mon_en = 1'b0;
  logic [31:0] ref_mem[16];
  logic [31:0] slv_mem[16];

  always @(posedge clk) cyc <= cyc + 1;

  // Protocol monitor: a VALID seen without READY must persist with unchanged payload.
  logic        p_awv = 1'b0, p_wv = 1'b0, p_arv = 1'b0;
  logic [31:0] p_awa = '0, p_wd = '0, p_ara = '0;
  logic [3:0]  p_ws = '0;
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (p_awv && (!aw_valid || aw_addr !== p_awa)) proto_err <= proto_err + 1;
      if (p_wv && (!w_valid || w_data !== p_wd || w_strb !== p_ws)) proto_err <= proto_err + 1;
      if (p_arv && (!ar_valid || ar_addr !== p_ara)) proto_err <= proto_err + 1;
      if ((aw_valid || w_valid || b_ready) && (ar_valid || r_ready)) proto_err <= proto_err + 1;
    end
    p_awv <= aw_valid && !aw_ready;
    p_wv  <= w_valid && !w_ready;
    p_arv <= ar_valid && !ar_ready;
    p_awa <= aw_addr;
    p_wd  <= w_data;
    p_ws  <= w_strb;
    p_ara <= ar_addr;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] rdata, input logic [2:0] status);
    rsp_t e;
    e.rdata  = rdata;
    e.status = status;
    exp_q.push_back(e);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] m;
    m = old;
    for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = d[8*b +: 8];
    return m;
  endfunction

  // Present a command, wait for acceptance, return the cycle count just before the accepting edge.
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output int t0);
    int n;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = s;
    n = 0;
    while (!cmd_ready && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) chk("cmd_accept_timeout", cmd_ready, 1);
    t0 = cyc;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic take_rsp(input string tag, input int stall);
    int   n;
    rsp_t e;
    rsp_ready = 1'b0;
    for (int i = 0; i < stall; i++) step();
    rsp_ready = 1'b1;
    n = 0;
    while (!rsp_valid && n < 100) begin
      step();
      n++;
    end
    chk({tag, "_rsp_valid"}, rsp_valid, 1);
    chk({tag, "_sb_nonempty"}, exp_q.size() > 0, 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_rdata"}, rsp_rdata, e.rdata);
      chk({tag, "_status"}, rsp_status, e.status);
    end
    step();
    rsp_ready = 1'b0;
    chk({tag, "_after_hs"}, {rsp_valid, cmd_ready}, 2'b01);
  endtask

  // Randomly stalling slave backed by slv_mem; runs until the DUT raises rsp_valid.
  task automatic serve();
    int          n = 0;
    bit          aw_got = 0, w_got = 0, ar_got = 0, bhs, rhs;
    logic [31:0] wa = '0, wd = '0, ra = '0;
    logic [3:0]  ws = '0;
    b_resp = 2'b00;
    r_resp = 2'b00;
    while (!rsp_valid && n < 200) begin
      aw_ready = ($urandom_range(0, 2) != 0);
      w_ready  = ($urandom_range(0, 2) != 0);
      ar_ready = ($urandom_range(0, 2) != 0);
      if (!b_valid && aw_got && w_got) b_valid = ($urandom_range(0, 2) != 0);
      if (!r_valid && ar_got) begin
        r_valid = ($urandom_range(0, 2) != 0);
        r_data  = slv_mem[ra[5:2]];
      end
      if (aw_valid && aw_ready) begin aw_got = 1; wa = aw_addr; end
      if (w_valid && w_ready) begin w_got = 1; wd = w_data; ws = w_strb; end
      if (ar_valid && ar_ready) begin ar_got = 1; ra = ar_addr; end
      bhs = b_valid && b_ready;
      rhs = r_valid && r_ready;
      step();
      n++;
      if (bhs) begin
        b_valid = 1'b0;
        slv_mem[wa[5:2]] = merge(slv_mem[wa[5:2]], wd, ws);
      end
      if (rhs) r_valid = 1'b0;
    end
    aw_ready = 1'b0;
    w_ready  = 1'b0;
    ar_ready = 1'b0;
    chk("rnd_serve_done", rsp_valid, 1);
  endtask

  initial begin
    int          t0, cnt, idx;
    bit          ok, wr;
    logic [31:0] a, d;
    logic [3:0]  s;

    // Reset state
    #12;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_handshakes", {aw_valid, w_valid, b_ready, ar_valid, r_ready, rsp_valid}, 6'b0);
    chk("rst_payload", |{aw_addr, ar_addr, w_data, w_strb}, 0);
    chk("rst_rsp", {rsp_rdata, rsp_status}, 35'b0);
    step();
    rst_n = 1'b1;
    step();

    // Zero-wait read
    push_exp(32'hDEADBEEF, 3'b000);
    issue(1'b0, 32'h4A10_0000, 32'h0, 4'h0, t0);
    chk("rd_ar_valid", {ar_valid, aw_valid, w_valid, cmd_ready}, 4'b1000);
    chk("rd_ar_addr", ar_addr, 32'h4A10_0000);
    ar_ready = 1'b1;
    step();
    ar_ready = 1'b0;
    chk("rd_r_ready", {ar_valid, r_ready}, 2'b01);
    r_valid = 1'b1;
    r_data  = 32'hDEADBEEF;
    r_resp  = 2'b00;
    step();
    r_valid = 1'b0;
    r_data  = '0;
    chk("rd_latency", {rsp_valid, 32'(cyc - t0)}, {1'b1, 32'd3});
    chk("rd_r_ready_drop", r_ready, 0);
    take_rsp("rd", 0);

    // Write: w_ready four cycles ahead of aw_ready
    push_exp(32'h0, 3'b000);
    issue(1'b1, 32'h0000_1000, 32'h1234_5678, 4'hF, t0);
    chk("wr_valids", {aw_valid, w_valid, b_ready}, 3'b110);
    chk("wr_payload", {aw_addr, w_data}, {32'h0000_1000, 32'h1234_5678});
    chk("wr_strb", w_strb, 4'hF);
    w_ready = 1'b1;
    step();
    w_ready = 1'b0;
    chk("wr_w_drop", {aw_valid, w_valid, b_ready}, 3'b100);
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      ok &= aw_valid && !w_valid && !b_ready && (aw_addr == 32'h0000_1000);
    end
    chk("wr_aw_hold", ok, 1);
    aw_ready = 1'b1;
    step();
    aw_ready = 1'b0;
    chk("wr_b_ready", {aw_valid, w_valid, b_ready}, 3'b001);
    b_valid = 1'b1;
    b_resp  = 2'b00;
    step();
    b_valid = 1'b0;
    chk("wr_b_done", {b_ready, rsp_valid}, 2'b01);
    take_rsp("wr", 0);

    // SLVERR write held under response backpressure
    push_exp(32'h0, 3'b010);
    issue(1'b1, 32'h0000_2004, 32'hCAFE_F00D, 4'h3, t0);
    aw_ready = 1'b1;
    w_ready  = 1'b1;
    step();
    aw_ready = 1'b0;
    w_ready  = 1'b0;
    b_valid  = 1'b1;
    b_resp   = 2'b10;
    step();
    b_valid = 1'b0;
    b_resp  = 2'b00;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0000_0040;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ok &= rsp_valid && (rsp_status == 3'b010) && (rsp_rdata == 32'h0) && !cmd_ready
            && !ar_valid && !aw_valid;
      step();
    end
    cmd_valid = 1'b0;
    chk("bp_hold", ok, 1);
    take_rsp("slverr", 0);

    // Read timeout with ar_ready stuck low, then late responses
    push_exp(32'h0, 3'b111);
    issue(1'b0, 32'h4A10_0040, 32'h0, 4'h0, t0);
    cnt = 0;
    while (ar_valid && cnt < 40) begin
      cnt++;
      step();
    end
    chk("to_ar_cycles", cnt, 16);
    chk("to_rsp", {rsp_valid, rsp_status}, 4'b1111);
    r_valid  = 1'b1;
    r_data   = 32'h5555_AAAA;
    ar_ready = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      ok &= !r_ready && !ar_valid && rsp_valid && (rsp_rdata == 32'h0);
    end
    chk("to_late_ignored", ok, 1);
    take_rsp("timeout", 0);
    r_valid  = 1'b0;
    r_data   = '0;
    ar_ready = 1'b0;
    step();
    chk("to_no_extra_rsp", {rsp_valid, r_ready, ar_valid}, 3'b000);

    // Reset while waiting for the write response
    issue(1'b1, 32'h0000_3000, 32'hA5A5_5A5A, 4'hF, t0);
    aw_ready = 1'b1;
    w_ready  = 1'b1;
    step();
    aw_ready = 1'b0;
    w_ready  = 1'b0;
    chk("rstmid_b_ready", b_ready, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_async", {aw_valid, w_valid, b_ready, ar_valid, r_ready, rsp_valid, cmd_ready},
        7'b0000001);
    chk("rstmid_addr", aw_addr, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("rstmid_after", {cmd_ready, rsp_valid, aw_valid, w_valid, b_ready}, 5'b10000);

    // Randomized back-to-back traffic against a slave memory
    for (int i = 0; i < 16; i++) begin
      slv_mem[i] = $urandom;
      ref_mem[i] = slv_mem[i];
    end
    mon_en = 1'b1;
    for (int k = 0; k < 100; k++) begin
      wr  = 1'($urandom_range(0, 1));
      idx = $urandom_range(0, 15);
      a   = 32'h4000_0000 | (32'(idx) << 2);
      d   = $urandom;
      s   = 4'($urandom_range(0, 15));
      if (wr) begin
        ref_mem[idx] = merge(ref_mem[idx], d, s);
        push_exp(32'h0, 3'b000);
      end else begin
        push_exp(ref_mem[idx], 3'b000);
      end
      issue(wr, a, d, s, t0);
      serve();
      take_rsp(wr ? "rnd_wr" : "rnd_rd", $urandom_range(0, 2));
    end
    step();
    mon_en = 1'b0;
    chk("protocol", proto_err, 0);
    chk("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
